lsu: RTL and testbench

- Load/store unit between the core datapath and the data memory port. It sits directly upstream of the data memory.
- Converts core load/store requests (byte address, RV32 size code) into word-lane memory transactions: byte enables, lane-replicated write data, request handshake.
- Extracts and sign/zero-extends returned read data.
- Stalls the core for the memory's one-cycle read latency and rejects misaligned or illegal-size accesses.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_if.sv | 36 +++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu.sv | 102 ++++++++++
 tb/tb_lsu.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store size codes and the memory-side size classes they map onto.
package lsu_pkg;

  // RV32 funct3 size codes as seen by the decoder and the LSU
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  // Access width classes on the data memory port
  localparam logic [1:0] DATA_MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] DATA_MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] DATA_MEM_SIZE_WORD = 2'd2;

  // Signedness does not matter on the memory side; fold BU/HU onto B/H
  function automatic logic [1:0] mem_size(input logic [2:0] sz);
    case (sz)
      LDST_B, LDST_BU: mem_size = DATA_MEM_SIZE_BYTE;
      LDST_H, LDST_HU: mem_size = DATA_MEM_SIZE_HALF;
      default:         mem_size = DATA_MEM_SIZE_WORD;
    endcase
  endfunction

  // Size code is defined and the address is naturally aligned for it
  function automatic logic size_legal(input logic [2:0] sz, input logic [1:0] off);
    case (sz)
      LDST_B, LDST_BU: size_legal = 1'b1;
      LDST_H, LDST_HU: size_legal = ~off[0];
      LDST_W:          size_legal = (off == 2'b00);
      default:         size_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side and memory-side signals of the load/store unit.
interface lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  core_req_i;
  logic                  core_we_i;
  logic [2:0]            core_size_i;
  logic [ADDR_WIDTH-1:0] core_addr_i;
  logic [31:0]           core_wd_i;
  logic [31:0]           core_rd_o;
  logic                  core_stall_o;
  logic                  core_err_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wd_o;
  logic [31:0]           mem_rd_i;
  logic                  mem_ready_i;

  // The LSU itself
  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, core_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  // Whatever drives the core requests and models the memory
  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, core_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed lane out of a memory read word and extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rd_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mem_rd_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

  // Sign- or zero-extend the selected lane according to the captured size code
  always_comb begin
    case (size_i)
      LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data_o = {24'h0, byte_sel};
      LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data_o = {16'h0, half_sel};
      default: data_o = mem_rd_i;
    endcase
  end
endmodule

// File: rtl/lsu.sv
// Load/store unit: turns core byte-addressed accesses into word-lane memory
// transactions and stalls the core across the one-cycle read latency.
//
// state | meaning
// IDLE  | no access in flight; a legal core request is issued combinationally
// RESP  | request accepted last cycle; memory read word is valid, core released
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input logic  clk_i,
  input logic  rst_i,
  lsu_if.slave bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] size_q, size_d;
  logic [1:0] off_q, off_d;
  logic       we_q, we_d;

  logic [1:0]  off;
  logic        err;
  logic        issue;
  logic [3:0]  be;
  logic [31:0] wd_rep;
  logic [31:0] ld_word;

  assign off   = bus.core_addr_i[1:0];
  assign err   = bus.core_req_i && !size_legal(bus.core_size_i, off);
  // Output gating with rst_i keeps every output low for as long as reset is held
  assign issue = !rst_i && (state_q == ST_IDLE) && bus.core_req_i && !err;

  // Lane enables and replicated store data from the access width
  always_comb begin
    be     = 4'b1111;
    wd_rep = bus.core_wd_i;
    case (mem_size(bus.core_size_i))
      DATA_MEM_SIZE_BYTE: begin
        be     = 4'b0001 << off;
        wd_rep = {4{bus.core_wd_i[7:0]}};
      end
      DATA_MEM_SIZE_HALF: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{bus.core_wd_i[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_load_align (
    .mem_rd_i (bus.mem_rd_i),
    .size_i   (size_q),
    .off_i    (off_q),
    .data_o   (ld_word)
  );

  assign bus.mem_req_o    = issue;
  assign bus.mem_we_o     = issue && bus.core_we_i;
  assign bus.mem_be_o     = issue ? be : 4'b0000;
  assign bus.mem_addr_o   = issue ? bus.core_addr_i : {ADDR_WIDTH{1'b0}};
  assign bus.mem_wd_o     = issue ? wd_rep : 32'h0;
  assign bus.core_stall_o = issue;
  assign bus.core_err_o   = !rst_i && (state_q == ST_IDLE) && err;
  assign bus.core_rd_o    = (!rst_i && (state_q == ST_RESP) && !we_q) ? ld_word : 32'h0;

  // Next state: capture access shape on acceptance, RESP always lasts one cycle
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    off_d   = off_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE: begin
        if (issue && bus.mem_ready_i) begin
          state_d = ST_RESP;
          size_d  = bus.core_size_i;
          off_d   = off;
          we_d    = bus.core_we_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      off_q   <= off_d;
      we_q    <= we_d;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit with a scoreboard for core_rd_o.
module tb_lsu;
  import lsu_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd_word = 32'h80F0_7F81;

  always #5 clk_i = ~clk_i;

  lsu_if #(.ADDR_WIDTH(32)) bus ();

  lsu #(.ADDR_WIDTH(32)) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  // Memory model: read word registered one cycle after an accepted load
  always @(posedge clk_i)
    if (bus.mem_req_o && bus.mem_ready_i && !bus.mem_we_o)
      bus.mem_rd_i <= rd_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd);
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = we;
    bus.core_size_i = sz;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
  endtask

  // One accepted access: issue cycle then RESP cycle; entered and left at posedge+1 in IDLE
  task automatic access(input string tag, input logic we, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd);
    drive(we, sz, addr, wd);
    bus.mem_ready_i = 1'b1;
    exp_q.push_back(exp_rd);
    @(negedge clk_i);
    chk({tag, ".req"},   32'(bus.mem_req_o), 32'd1);
    chk({tag, ".we"},    32'(bus.mem_we_o), 32'(we));
    chk({tag, ".be"},    32'(bus.mem_be_o), 32'(exp_be));
    chk({tag, ".addr"},  bus.mem_addr_o, addr);
    chk({tag, ".stall"}, 32'(bus.core_stall_o), 32'd1);
    if (we) chk({tag, ".wd"}, bus.mem_wd_o, exp_wd);
    cyc();
    @(negedge clk_i);
    chk({tag, ".resp_req"},   32'(bus.mem_req_o), 32'd0);
    chk({tag, ".resp_stall"}, 32'(bus.core_stall_o), 32'd0);
    chk({tag, ".rd"},         bus.core_rd_o, exp_q.pop_front());
    cyc();
    bus.core_req_i = 1'b0;
  endtask

  task automatic illegal(input string tag, input logic we, input logic [2:0] sz,
                         input logic [31:0] addr);
    drive(we, sz, addr, 32'h5555_AAAA);
    bus.mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk({tag, ".err"},   32'(bus.core_err_o), 32'd1);
    chk({tag, ".req"},   32'(bus.mem_req_o), 32'd0);
    chk({tag, ".stall"}, 32'(bus.core_stall_o), 32'd0);
    cyc();
    bus.core_req_i = 1'b0;
  endtask

  initial begin
    drive(1'b1, LDST_W, 32'h10, 32'hDEAD_BEEF);
    bus.mem_ready_i = 1'b1;

    // Outputs held low while reset is asserted, even with a valid request present
    @(negedge clk_i);
    chk("rst.req",   32'(bus.mem_req_o), 32'd0);
    chk("rst.stall", 32'(bus.core_stall_o), 32'd0);
    chk("rst.err",   32'(bus.core_err_o), 32'd0);
    chk("rst.be",    32'(bus.mem_be_o), 32'd0);
    chk("rst.wd",    bus.mem_wd_o, 32'd0);
    chk("rst.rd",    bus.core_rd_o, 32'd0);
    cyc();
    rst_i = 1'b0;
    bus.core_req_i = 1'b0;
    @(negedge clk_i);
    chk("idle.req",   32'(bus.mem_req_o), 32'd0);
    chk("idle.stall", 32'(bus.core_stall_o), 32'd0);
    chk("idle.addr",  bus.mem_addr_o, 32'd0);
    chk("idle.rd",    bus.core_rd_o, 32'd0);
    cyc();

    // Stores
    access("sw",  1'b1, LDST_W, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    access("sb",  1'b1, LDST_B, 32'h13, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    access("sh",  1'b1, LDST_H, 32'h12, 32'h0000_1234, 4'b1100, 32'h1234_1234, 32'h0);

    // Loads against 0x80F07F81
    access("lb",  1'b0, LDST_B,  32'h100, 32'h0, 4'b0001, 32'h0, 32'hFFFF_FF81);
    access("lbu", 1'b0, LDST_BU, 32'h100, 32'h0, 4'b0001, 32'h0, 32'h0000_0081);
    access("lh",  1'b0, LDST_H,  32'h102, 32'h0, 4'b1100, 32'h0, 32'hFFFF_80F0);
    access("lhu", 1'b0, LDST_HU, 32'h102, 32'h0, 4'b1100, 32'h0, 32'h0000_80F0);
    access("lw",  1'b0, LDST_W,  32'h104, 32'h0, 4'b1111, 32'h0, 32'h80F0_7F81);
    access("lb3", 1'b0, LDST_B,  32'h103, 32'h0, 4'b1000, 32'h0, 32'hFFFF_FF80);

    // Illegal accesses; the following legal access proves the FSM stayed in IDLE
    illegal("lw_mis", 1'b0, LDST_W, 32'h102);
    access("after1", 1'b0, LDST_HU, 32'h100, 32'h0, 4'b0011, 32'h0, 32'h0000_7F81);
    illegal("sh_mis", 1'b1, LDST_H, 32'h101);
    access("after2", 1'b0, LDST_BU, 32'h101, 32'h0, 4'b0010, 32'h0, 32'h0000_007F);
    illegal("size3", 1'b0, 3'd3, 32'h100);
    access("after3", 1'b1, LDST_B, 32'h101, 32'h0000_0033, 4'b0010, 32'h3333_3333, 32'h0);

    // Backpressure: ready low for three cycles, request held stable
    drive(1'b0, LDST_W, 32'h20, 32'h0);
    bus.mem_ready_i = 1'b0;
    exp_q.push_back(32'h80F0_7F81);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_ready_i = 1'b1;
      @(negedge clk_i);
      chk($sformatf("bp%0d.req", i),   32'(bus.mem_req_o), 32'd1);
      chk($sformatf("bp%0d.stall", i), 32'(bus.core_stall_o), 32'd1);
      chk($sformatf("bp%0d.addr", i),  bus.mem_addr_o, 32'h20);
      chk($sformatf("bp%0d.be", i),    32'(bus.mem_be_o), 32'hF);
      cyc();
    end
    bus.mem_ready_i = 1'b0;
    bus.core_size_i = 3'd3;
    @(negedge clk_i);
    chk("bp.resp_stall", 32'(bus.core_stall_o), 32'd0);
    chk("bp.resp_req",   32'(bus.mem_req_o), 32'd0);
    chk("bp.resp_err",   32'(bus.core_err_o), 32'd0);
    chk("bp.rd",         bus.core_rd_o, exp_q.pop_front());
    cyc();
    bus.core_req_i = 1'b0;
    bus.mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp.done_req", 32'(bus.mem_req_o), 32'd0);
    cyc();

    // Reset asserted asynchronously during RESP
    drive(1'b0, LDST_W, 32'h40, 32'h0);
    exp_q.push_back(32'h80F0_7F81);
    @(negedge clk_i);
    chk("rm.req", 32'(bus.mem_req_o), 32'd1);
    cyc();
    @(negedge clk_i);
    chk("rm.rd", bus.core_rd_o, exp_q.pop_front());
    #1 rst_i = 1'b1;
    #1;
    chk("rm.rd0",    bus.core_rd_o, 32'd0);
    chk("rm.req0",   32'(bus.mem_req_o), 32'd0);
    chk("rm.stall0", 32'(bus.core_stall_o), 32'd0);
    chk("rm.err0",   32'(bus.core_err_o), 32'd0);
    chk("rm.be0",    32'(bus.mem_be_o), 32'd0);
    cyc();
    rst_i = 1'b0;
    bus.core_req_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk($sformatf("rm.idle%0d.req", i),   32'(bus.mem_req_o), 32'd0);
      chk($sformatf("rm.idle%0d.stall", i), 32'(bus.core_stall_o), 32'd0);
      chk($sformatf("rm.idle%0d.rd", i),    bus.core_rd_o, 32'd0);
      cyc();
    end
    access("post_rst", 1'b0, LDST_H, 32'h100, 32'h0, 4'b0011, 32'h0, 32'h0000_7F81);

    chk("sb.empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
